// File: rtl/pc_call_stack.sv
// pc_call_stack: parametrised LIFO return-address stack (CALL push / RET pop).
// Optional macro PC_CALL_STACK_CIRC_EN: push on full discards the oldest entry.
module pc_call_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    top;
  logic [AW-1:0]    wp_nxt;
  logic [AW:0]      cnt_nxt;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic             ovf_set;
  logic             unf_set;
  logic             op_repl;
  logic             op_push;
  logic             op_drop;
  logic             op_pop;
  logic             op_unf;

  assign top   = wp - 1'b1;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = empty ? '0 : mem[top];

  // full implies !empty, so these five terms are mutually exclusive
  assign op_repl = push & pop & ~empty;
  assign op_push = push & ~full & ~op_repl;
  assign op_drop = push & ~pop & full;
  assign op_pop  = pop & ~push & ~empty;
  assign op_unf  = pop & ~push & empty;

  // decode the requested operation into next pointer/count and write
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wp;
    wp_nxt  = wp;
    cnt_nxt = count;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      op_repl: begin
        wr_en   = 1'b1;
        wr_addr = top;
      end
      op_push: begin
        wr_en   = 1'b1;
        wp_nxt  = wp + 1'b1;
        cnt_nxt = count + 1'b1;
      end
      op_drop: begin
        ovf_set = 1'b1;
`ifdef PC_CALL_STACK_CIRC_EN
        wr_en   = 1'b1;
        wp_nxt  = wp + 1'b1;
`endif
      end
      op_pop: begin
        wp_nxt  = wp - 1'b1;
        cnt_nxt = count - 1'b1;
      end
      op_unf: begin
        unf_set = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // pointer, occupancy and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      wp    <= wp_nxt;
      count <= cnt_nxt;
      ovf   <= ovf_set | (ovf & ~err_clr);
      unf   <= unf_set | (unf & ~err_clr);
    end
  end

  // storage array, contents left undefined by reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= din;
  end

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: queue-model check of two stack configurations.
// Covers default 11x16 and a 16x4 instance with shared push/pop.
module tb_pc_call_stack;

`ifdef PC_CALL_STACK_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        err_clr = 1'b0;
  logic [10:0] din = '0;
  logic [15:0] din2 = '0;

  logic [10:0] a_dout;
  logic [4:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_unf;
  logic [15:0] b_dout;
  logic [2:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_unf;

  pc_call_stack #(.WIDTH(11), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(din), .err_clr(err_clr), .dout(a_dout),
    .count(a_count), .empty(a_empty), .full(a_full),
    .ovf(a_ovf), .unf(a_unf)
  );

  pc_call_stack #(.WIDTH(16), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(din2), .err_clr(err_clr), .dout(b_dout),
    .count(b_count), .empty(b_empty), .full(b_full),
    .ovf(b_ovf), .unf(b_unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string nm,
                       input int unsigned act,
                       input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // reference model: newest entry at the back of each queue
  logic [10:0] qa[$];
  logic [15:0] qb[$];
  bit ova, una, ovb, unb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete(); qb.delete();
      ova = 0; una = 0; ovb = 0; unb = 0;
    end else begin
      bit os, us;
      os = 0; us = 0;
      if (push && pop && qa.size() > 0) qa[qa.size()-1] = din;
      else if (push) begin
        if (qa.size() < 16) qa.push_back(din);
        else begin
          os = 1;
          if (CIRC) begin void'(qa.pop_front()); qa.push_back(din); end
        end
      end else if (pop) begin
        if (qa.size() > 0) void'(qa.pop_back());
        else us = 1;
      end
      ova = os | (ova & !err_clr);
      una = us | (una & !err_clr);
      os = 0; us = 0;
      if (push && pop && qb.size() > 0) qb[qb.size()-1] = din2;
      else if (push) begin
        if (qb.size() < 4) qb.push_back(din2);
        else begin
          os = 1;
          if (CIRC) begin void'(qb.pop_front()); qb.push_back(din2); end
        end
      end else if (pop) begin
        if (qb.size() > 0) void'(qb.pop_back());
        else us = 1;
      end
      ovb = os | (ovb & !err_clr);
      unb = us | (unb & !err_clr);
    end
  end

  // compare every settled cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("a_dout", a_dout, qa.size() > 0 ? qa[qa.size()-1] : 0);
      check("a_count", a_count, qa.size());
      check("a_empty", a_empty, qa.size() == 0);
      check("a_full", a_full, qa.size() == 16);
      check("a_ovf", a_ovf, ova);
      check("a_unf", a_unf, una);
      check("b_dout", b_dout, qb.size() > 0 ? qb[qb.size()-1] : 0);
      check("b_count", b_count, qb.size());
      check("b_empty", b_empty, qb.size() == 0);
      check("b_full", b_full, qb.size() == 4);
      check("b_ovf", b_ovf, ovb);
      check("b_unf", b_unf, unb);
    end
  end

  task automatic op(input bit p, input bit q, input logic [10:0] d,
                    input logic [15:0] d2, input bit e);
    push = p; pop = q; din = d; din2 = d2; err_clr = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_dout", a_dout, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // fill
    for (int i = 1; i <= 16; i++) op(1, 0, 11'(32'h100 + i), 16'(i), 0);
    check("fill_full", a_full, 1);
    check("fill_count", a_count, 16);
    check("fill_dout", a_dout, 'h110);
    check("b_fill_count", b_count, 4);
    check("b_fill_ovf", b_ovf, 1);

    // overflow
    op(1, 0, 11'h7FF, 16'h7FF, 0);
    check("ovf_count", a_count, 16);
    check("ovf_flag", a_ovf, 1);
    check("ovf_dout", a_dout, CIRC ? 'h7FF : 'h110);

    // drain
    for (int i = 0; i < 16; i++) begin
      int unsigned e;
      if (CIRC) e = (i == 0) ? 'h7FF : 'h111 - i;
      else e = 'h110 - i;
      check("drain_dout", a_dout, e);
      op(0, 1, 0, 0, 0);
    end
    check("drain_empty", a_empty, 1);
    check("drain_dout0", a_dout, 0);

    // underflow and clear
    op(0, 1, 0, 0, 0);
    check("unf_set", a_unf, 1);
    check("unf_count", a_count, 0);
    op(0, 0, 0, 0, 1);
    check("unf_clr", a_unf, 0);
    check("ovf_clr", a_ovf, 0);
    op(0, 1, 0, 0, 1);
    check("unf_wins", a_unf, 1);
    op(0, 0, 0, 0, 1);

    // replace top
    op(1, 0, 11'h010, 16'h010, 0);
    op(1, 0, 11'h020, 16'h020, 0);
    op(1, 1, 11'h030, 16'h030, 0);
    check("repl_count", a_count, 2);
    check("repl_dout", a_dout, 'h030);
    op(0, 1, 0, 0, 0);
    check("repl_pop", a_dout, 'h010);
    op(0, 1, 0, 0, 0);
    op(1, 1, 11'h055, 16'h055, 0);
    check("pp_empty_cnt", a_count, 1);
    check("pp_empty_unf", a_unf, 0);
    check("pp_empty_dout", a_dout, 'h055);

    // asynchronous reset mid-stream
    op(0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0);
    check("pre_rst_unf", a_unf, 1);
    rst = 1'b1;
    #2;
    check("mrst_dout", a_dout, 0);
    check("mrst_count", a_count, 0);
    check("mrst_empty", a_empty, 1);
    check("mrst_full", a_full, 0);
    check("mrst_unf", a_unf, 0);
    check("mrst_b_dout", b_dout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push = 0; pop = 0; err_clr = 0;

    // small-stack fill/drain wrap
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++)
        op(1, 0, 11'(i), 16'(32'hA000 + c * 16 + i), 0);
      check("b_wrap_full", b_full, 1);
      check("b_wrap_dout", b_dout, 'hA000 + c * 16 + 3);
      for (int i = 0; i < 4; i++) op(0, 1, 0, 0, 0);
      check("b_wrap_empty", b_empty, 1);
    end

    // random phases biased toward filling or draining
    for (int ph = 0; ph < 40; ph++) begin
      int bias;
      bias = (ph % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 60; k++) begin
        bit p, q, e;
        p = ($urandom_range(0, 99) < bias);
        q = ($urandom_range(0, 99) < 100 - bias);
        e = ($urandom_range(0, 15) == 0);
        op(p, q, 11'($urandom), 16'($urandom), e);
      end
    end

    push = 0; pop = 0; err_clr = 0;
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
